// File: rtl/maxpool_pkg.sv
// maxpool_pkg
// Shared definitions for the max-pool sequencer slice: feature-map geometry,
// counter widths, terminal-count constants and the controller state encoding.
// No ports; imported by maxpool_ctrl_if, maxpool_row_packer and maxpool_ctrl.
// ROW_W and ROWS must both be even so that 2x2 windows tile the map exactly.

package maxpool_pkg;

   localparam int ROW_W    = 24;
   localparam int ROWS     = 24;
   localparam int CH_W     = 8;
   localparam int DIN_W    = 5;
   localparam int OUT_W    = ROW_W / 2;
   localparam int OUT_ROWS = ROWS / 2;
   localparam int DRAIN_TO = 16;

   localparam int PIX_CNT_W  = $clog2(ROW_W * ROWS);
   localparam int RES_CNT_W  = $clog2(OUT_W * OUT_ROWS + 1);
   localparam int ROW_IDX_W  = $clog2(OUT_ROWS);
   localparam int COL_IDX_W  = $clog2(OUT_W);
   localparam int IDLE_CNT_W = $clog2(DRAIN_TO + 1);

   // Terminal counts sized to their counters so compares stay width-matched.
   localparam logic [PIX_CNT_W-1:0]  PIX_LAST  = PIX_CNT_W'(ROW_W * ROWS - 1);
   localparam logic [RES_CNT_W-1:0]  RES_TOTAL = RES_CNT_W'(OUT_W * OUT_ROWS);
   localparam logic [COL_IDX_W-1:0]  COL_LAST  = COL_IDX_W'(OUT_W - 1);
   localparam logic [ROW_IDX_W-1:0]  ROW_LAST  = ROW_IDX_W'(OUT_ROWS - 1);
   localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(DRAIN_TO - 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      CLEAR,
      DONE
   } state_t;

endpackage

// File: rtl/maxpool_ctrl_if.sv
// maxpool_ctrl_if
// Streaming interface of the max-pool sequencer.
//   s_valid/s_ready/s_data : signed pixel stream from the convolution stage
//   m_valid/m_data/m_row/m_ch/m_last : pooled row words (no backpressure)
// modport slave  : the controller side (consumes pixels, produces rows)
// modport master : the environment side (produces pixels, consumes rows)

interface maxpool_ctrl_if;
   import maxpool_pkg::*;

   logic                    s_valid;
   logic                    s_ready;
   logic signed [DIN_W-1:0] s_data;

   logic                    m_valid;
   logic [OUT_W-1:0]        m_data;
   logic [ROW_IDX_W-1:0]    m_row;
   logic [CH_W-1:0]         m_ch;
   logic                    m_last;

   modport slave (
      input  s_valid, s_data,
      output s_ready,
      output m_valid, m_data, m_row, m_ch, m_last
   );

   modport master (
      output s_valid, s_data,
      input  s_ready,
      input  m_valid, m_data, m_row, m_ch, m_last
   );

endinterface

// File: rtl/maxpool_row_packer.sv
// maxpool_row_packer
// Collects the pool's one-bit results into OUT_W-bit row words.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : drop any partial row and restart at row 0 / column 0
//   en        : results are only taken while the controller is RUN or DRAIN
//   ovalid/dout : pool result strobe and bit
//   ch_idx, last_ch : channel tag and "this is the final channel" flag
//   m_valid/m_data/m_row/m_ch/m_last : registered row word, one-cycle pulse

module maxpool_row_packer
   import maxpool_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 ovalid,
   input  logic                 dout,
   input  logic [CH_W-1:0]      ch_idx,
   input  logic                 last_ch,
   output logic                 m_valid,
   output logic [OUT_W-1:0]     m_data,
   output logic [ROW_IDX_W-1:0] m_row,
   output logic [CH_W-1:0]      m_ch,
   output logic                 m_last
);

   logic [COL_IDX_W-1:0] col;
   logic [ROW_IDX_W-1:0] row;
   logic [OUT_W-1:0]     partial;
   logic [OUT_W-1:0]     word;

   // Bit i of the word is output column i, so the incoming bit lands at col.
   always_comb begin
      word      = partial;
      word[col] = dout;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         col     <= '0;
         row     <= '0;
         partial <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_row   <= '0;
         m_ch    <= '0;
         m_last  <= 1'b0;
      end else begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         if (clr) begin
            col     <= '0;
            row     <= '0;
            partial <= '0;
         end else if (en && ovalid) begin
            if (col == COL_LAST) begin
               col     <= '0;
               partial <= '0;
               m_data  <= word;
               m_valid <= 1'b1;
               m_row   <= row;
               m_ch    <= ch_idx;
               m_last  <= last_ch && (row == ROW_LAST);
               row     <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col     <= col + 1'b1;
               partial <= word;
            end
         end
      end
   end

endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl
// Sequencer around the 2x2 binary max-pool datapath. Streams one ROW_W x ROWS
// feature map per channel into the pool, gathers its result bits into row
// words, repeats for the programmed channel count and pulses done.
//   clk, rstn      : clock, synchronous active-low reset
//   start, abort   : job start (IDLE only) / return to IDLE from anywhere
//   cfg_num_ch     : channel count, latched on start
//   io (slave)     : pixel stream in, pooled row words out
//   pool_state/pool_ivalid/pool_din : drive the pool datapath
//   pool_ovalid/pool_dout           : pool results
//   busy, done, err_timeout         : status
// Optional build macro MAXPOOL_CTRL_PERF_EN adds perf_stall and perf_cycles,
// saturating 32-bit counters cleared on start.

module maxpool_ctrl
   import maxpool_pkg::*;
(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic                    abort,
   input  logic [CH_W-1:0]         cfg_num_ch,
   maxpool_ctrl_if.slave           io,
   output logic                    pool_state,
   output logic                    pool_ivalid,
   output logic signed [DIN_W-1:0] pool_din,
   input  logic                    pool_ovalid,
   input  logic                    pool_dout,
   output logic                    busy,
   output logic                    done,
   output logic                    err_timeout
`ifdef MAXPOOL_CTRL_PERF_EN
   ,
   output logic [31:0]             perf_stall,
   output logic [31:0]             perf_cycles
`endif
);

   state_t               state;
   logic                 s_ready_q;
   logic [CH_W-1:0]      num_ch;
   logic [CH_W-1:0]      ch_idx;
   logic [PIX_CNT_W-1:0] pix_cnt;
   logic [RES_CNT_W-1:0] res_cnt;
   logic [IDLE_CNT_W-1:0] idle_cnt;

   logic accept;
   logic collect;
   logic last_ch;
   logic pk_clr;

   logic                 pk_m_valid;
   logic [OUT_W-1:0]     pk_m_data;
   logic [ROW_IDX_W-1:0] pk_m_row;
   logic [CH_W-1:0]      pk_m_ch;
   logic                 pk_m_last;

   // The pool sees the handshake directly: no pipeline stage on the pixels.
   assign accept      = io.s_valid & s_ready_q;
   assign pool_ivalid = accept;
   assign pool_din    = io.s_data;
   assign io.s_ready  = s_ready_q;

   assign collect = (state == RUN) || (state == DRAIN);
   assign last_ch = (ch_idx == num_ch - 1'b1);
   // Outside RUN/DRAIN the packer is held clear, so a partial row left by a
   // timeout or abort never leaks into the next channel or job.
   assign pk_clr  = abort || !collect;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         s_ready_q   <= 1'b0;
         pool_state  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         num_ch      <= '0;
         ch_idx      <= '0;
         pix_cnt     <= '0;
         res_cnt     <= '0;
         idle_cnt    <= '0;
      end else if (abort) begin
         state      <= IDLE;
         s_ready_q  <= 1'b0;
         pool_state <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pix_cnt    <= '0;
         res_cnt    <= '0;
         idle_cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  num_ch      <= cfg_num_ch;
                  ch_idx      <= '0;
                  err_timeout <= 1'b0;
                  pix_cnt     <= '0;
                  res_cnt     <= '0;
                  idle_cnt    <= '0;
                  busy        <= 1'b1;
                  if (cfg_num_ch == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state      <= RUN;
                     s_ready_q  <= 1'b1;
                     pool_state <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (pool_ovalid) begin
                  res_cnt <= res_cnt + 1'b1;
               end
               if (accept) begin
                  if (pix_cnt == PIX_LAST) begin
                     pix_cnt   <= '0;
                     idle_cnt  <= '0;
                     s_ready_q <= 1'b0;
                     state     <= DRAIN;
                  end else begin
                     pix_cnt <= pix_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (pool_ovalid) begin
                  res_cnt  <= res_cnt + 1'b1;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
               // A complete result set wins over a coincident timeout.
               if (res_cnt >= RES_TOTAL) begin
                  state      <= CLEAR;
                  pool_state <= 1'b0;
               end else if (!pool_ovalid && (idle_cnt == IDLE_LAST)) begin
                  err_timeout <= 1'b1;
                  state       <= CLEAR;
                  pool_state  <= 1'b0;
               end
            end
            CLEAR: begin
               pix_cnt  <= '0;
               res_cnt  <= '0;
               idle_cnt <= '0;
               ch_idx   <= ch_idx + 1'b1;
               if (last_ch) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state      <= RUN;
                  s_ready_q  <= 1'b1;
                  pool_state <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               s_ready_q  <= 1'b0;
               pool_state <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   maxpool_row_packer u_packer (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (pk_clr),
      .en      (collect),
      .ovalid  (pool_ovalid),
      .dout    (pool_dout),
      .ch_idx  (ch_idx),
      .last_ch (last_ch),
      .m_valid (pk_m_valid),
      .m_data  (pk_m_data),
      .m_row   (pk_m_row),
      .m_ch    (pk_m_ch),
      .m_last  (pk_m_last)
   );

   assign io.m_valid = pk_m_valid;
   assign io.m_data  = pk_m_data;
   assign io.m_row   = pk_m_row;
   assign io.m_ch    = pk_m_ch;
   assign io.m_last  = pk_m_last;

`ifdef MAXPOOL_CTRL_PERF_EN
   // Stall = RUN cycles with no pixel offered; cycles = every busy cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_stall  <= '0;
         perf_cycles <= '0;
      end else if ((state == IDLE) && start && !abort) begin
         perf_stall  <= '0;
         perf_cycles <= '0;
      end else begin
         if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 1'b1;
         end
         if ((state == RUN) && !io.s_valid && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 1'b1;
         end
      end
   end
`endif

endmodule
